mem_stage: RTL and testbench



---
 rtl/mem_stage_if.sv | 15 +
 rtl/mem_stage.sv | 115 +++++++++++
 tb/tb_mem_stage.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/mem_stage_if.sv
// Data-memory request/acknowledge bus between the memory stage (master) and data memory (slave).
interface mem_stage_if #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned ADDR_WIDTH = 8
);
    logic                  req;
    logic                  we;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] wdata;
    logic                  ack;
    logic [DATA_WIDTH-1:0] rdata;

    modport master (output req, we, addr, wdata, input ack, rdata);
    modport slave  (input req, we, addr, wdata, output ack, rdata);
endinterface

// File: rtl/mem_stage.sv
// Pipeline memory stage: data-memory access FSM with stall, branch/jump resolution,
// M-stage forwarding value and the MEM/WB pipeline register.
module mem_stage #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned IMM8_WIDTH = 8,
    parameter int unsigned REG_WIDTH  = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [ADDR_WIDTH-1:0] PCM_i,
    input  logic [DATA_WIDTH-1:0] WriteDataM_i,
    input  logic [IMM8_WIDTH-1:0] imm8M_i,
    input  logic [REG_WIDTH-1:0]  WriteRegM_i,
    input  logic [DATA_WIDTH-1:0] alu_outM_i,
    input  logic                  RegWriteM_i,
    input  logic                  BranchM_i,
    input  logic                  MemReadM_i,
    input  logic                  MemWriteM_i,
    input  logic                  MemToRegM_i,
    input  logic                  MovM_i,
    input  logic                  jumpM_i,
    mem_stage_if.master           dmem,
    output logic                  stall_o,
    output logic                  pc_src_o,
    output logic [ADDR_WIDTH-1:0] pc_target_o,
    output logic [DATA_WIDTH-1:0] WBResultM_o,
    output logic [DATA_WIDTH-1:0] ReadDataW_o,
    output logic [DATA_WIDTH-1:0] alu_outW_o,
    output logic [REG_WIDTH-1:0]  WriteRegW_o,
    output logic                  RegWriteW_o,
    output logic                  MemToRegW_o
);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t                state;
    state_t                state_nxt;
    logic                  memop;
    logic                  taken;
    logic [ADDR_WIDTH-1:0] imm_sext;
    logic [DATA_WIDTH-1:0] rdata_q;

    assign memop = MemReadM_i | MemWriteM_i;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        stall_o   = 1'b0;
        unique case (state)
            IDLE: begin
                if (memop) begin
                    state_nxt = BUSY;
                    stall_o   = 1'b1;
                end
            end
            BUSY: begin
                stall_o = 1'b1;
                if (dmem.ack) state_nxt = DONE;
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Request fields are launched from IDLE and frozen until ack; only req drops on ack.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dmem.req   <= 1'b0;
            dmem.we    <= 1'b0;
            dmem.addr  <= '0;
            dmem.wdata <= '0;
            rdata_q    <= '0;
        end else if (state == IDLE && memop) begin
            dmem.req   <= 1'b1;
            dmem.we    <= MemWriteM_i;
            dmem.addr  <= alu_outM_i[ADDR_WIDTH-1:0];
            dmem.wdata <= WriteDataM_i;
        end else if (state == BUSY && dmem.ack) begin
            dmem.req   <= 1'b0;
            rdata_q    <= dmem.rdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ReadDataW_o <= '0;
            alu_outW_o  <= '0;
            WriteRegW_o <= '0;
            RegWriteW_o <= 1'b0;
            MemToRegW_o <= 1'b0;
        end else if (!stall_o) begin
            ReadDataW_o <= rdata_q;
            alu_outW_o  <= alu_outM_i;
            WriteRegW_o <= WriteRegM_i;
            RegWriteW_o <= RegWriteM_i;
            MemToRegW_o <= MemToRegM_i;
        end else begin
            RegWriteW_o <= 1'b0;
            MemToRegW_o <= 1'b0;
        end
    end

    assign WBResultM_o = MovM_i ? DATA_WIDTH'(imm8M_i) : alu_outM_i;

    assign taken       = BranchM_i && (alu_outM_i == '0);
    assign pc_src_o    = taken | jumpM_i;
    assign imm_sext    = ADDR_WIDTH'(signed'(imm8M_i));
    assign pc_target_o = jumpM_i ? ADDR_WIDTH'(imm8M_i) : PCM_i + imm_sext;

endmodule

// File: tb/tb_mem_stage.sv
// Directed self-checking bench for mem_stage: reset, loads/stores with ack latency,
// branch/jump targets, forwarding mux and back-to-back accesses.
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  PCM;
    logic [15:0] WriteDataM;
    logic [7:0]  imm8M;
    logic [3:0]  WriteRegM;
    logic [15:0] alu_outM;
    logic        RegWriteM, BranchM, MemReadM, MemWriteM, MemToRegM, MovM, jumpM;
    logic        stall, pc_src;
    logic [7:0]  pc_target;
    logic [15:0] WBResultM, ReadDataW, alu_outW;
    logic [3:0]  WriteRegW;
    logic        RegWriteW, MemToRegW;

    int vectors = 0;
    int miscompares = 0;
    int req_rises = 0;
    logic req_prev = 1'b0;

    mem_stage_if #(.DATA_WIDTH(16), .ADDR_WIDTH(8)) dmem ();

    mem_stage #(
        .DATA_WIDTH(16), .ADDR_WIDTH(8), .IMM8_WIDTH(8), .REG_WIDTH(4)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .PCM_i(PCM), .WriteDataM_i(WriteDataM), .imm8M_i(imm8M),
        .WriteRegM_i(WriteRegM), .alu_outM_i(alu_outM),
        .RegWriteM_i(RegWriteM), .BranchM_i(BranchM), .MemReadM_i(MemReadM),
        .MemWriteM_i(MemWriteM), .MemToRegM_i(MemToRegM), .MovM_i(MovM),
        .jumpM_i(jumpM), .dmem(dmem),
        .stall_o(stall), .pc_src_o(pc_src), .pc_target_o(pc_target),
        .WBResultM_o(WBResultM), .ReadDataW_o(ReadDataW), .alu_outW_o(alu_outW),
        .WriteRegW_o(WriteRegW), .RegWriteW_o(RegWriteW), .MemToRegW_o(MemToRegW)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (dmem.req && !req_prev) req_rises++;
        req_prev = dmem.req;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic nop();
        PCM = 8'h00; WriteDataM = 16'h0; imm8M = 8'h00; WriteRegM = 4'h0; alu_outM = 16'h0;
        RegWriteM = 0; BranchM = 0; MemReadM = 0; MemWriteM = 0; MemToRegM = 0;
        MovM = 0; jumpM = 0;
    endtask

    initial begin
        rst_n = 1'b0;
        nop();
        dmem.ack = 1'b0;
        dmem.rdata = 16'h0;
        #12;
        chk("rst_req", 32'(dmem.req), 32'h0);
        chk("rst_we", 32'(dmem.we), 32'h0);
        chk("rst_addr", 32'(dmem.addr), 32'h0);
        chk("rst_wdata", 32'(dmem.wdata), 32'h0);
        chk("rst_rdataw", 32'(ReadDataW), 32'h0);
        chk("rst_aluw", 32'(alu_outW), 32'h0);
        chk("rst_regw", 32'(RegWriteW), 32'h0);
        chk("rst_stall", 32'(stall), 32'h0);
        @(negedge clk) rst_n = 1'b1;
        cyc();

        // branch / jump resolution
        PCM = 8'h05; imm8M = 8'hFE; BranchM = 1; alu_outM = 16'h0000; #1;
        chk("br_taken_src", 32'(pc_src), 32'h1);
        chk("br_taken_tgt", 32'(pc_target), 32'h03);
        alu_outM = 16'h0001; #1;
        chk("br_not_taken", 32'(pc_src), 32'h0);
        PCM = 8'hFF; imm8M = 8'h02; alu_outM = 16'h0000; #1;
        chk("br_wrap_tgt", 32'(pc_target), 32'h01);
        nop(); jumpM = 1; imm8M = 8'h40; PCM = 8'h12; #1;
        chk("jmp_src", 32'(pc_src), 32'h1);
        chk("jmp_tgt", 32'(pc_target), 32'h40);
        cyc();

        // forwarding mux and single-cycle non-memory instruction
        nop(); MovM = 1; imm8M = 8'h9A; alu_outM = 16'h1357; #1;
        chk("mov_fwd", 32'(WBResultM), 32'h009A);
        MovM = 0; #1;
        chk("alu_fwd", 32'(WBResultM), 32'h1357);
        RegWriteM = 1; WriteRegM = 4'h5; #1;
        chk("alu_stall", 32'(stall), 32'h0);
        cyc();
        nop(); #1;
        chk("alu_wb_regw", 32'(RegWriteW), 32'h1);
        chk("alu_wb_data", 32'(alu_outW), 32'h1357);
        chk("alu_wb_reg", 32'(WriteRegW), 32'h5);

        // load, ack after two idle BUSY cycles
        MemReadM = 1; alu_outM = 16'h0010; RegWriteM = 1; MemToRegM = 1; WriteRegM = 4'h3; #1;
        chk("ld_idle_stall", 32'(stall), 32'h1);
        chk("ld_idle_req", 32'(dmem.req), 32'h0);
        cyc();
        chk("ld_b1_req", 32'(dmem.req), 32'h1);
        chk("ld_b1_addr", 32'(dmem.addr), 32'h10);
        chk("ld_b1_we", 32'(dmem.we), 32'h0);
        chk("ld_b1_stall", 32'(stall), 32'h1);
        chk("ld_b1_bubble", 32'(RegWriteW), 32'h0);
        cyc();
        chk("ld_b2_stall", 32'(stall), 32'h1);
        chk("ld_b2_req", 32'(dmem.req), 32'h1);
        cyc();
        dmem.ack = 1; dmem.rdata = 16'hBEEF; #1;
        chk("ld_b3_stall", 32'(stall), 32'h1);
        cyc();
        dmem.ack = 0; dmem.rdata = 16'h0; #1;
        chk("ld_done_req", 32'(dmem.req), 32'h0);
        chk("ld_done_stall", 32'(stall), 32'h0);
        chk("ld_done_bubble", 32'(RegWriteW), 32'h0);
        cyc();
        nop(); #1;
        chk("ld_wb_data", 32'(ReadDataW), 32'hBEEF);
        chk("ld_wb_regw", 32'(RegWriteW), 32'h1);
        chk("ld_wb_m2r", 32'(MemToRegW), 32'h1);
        chk("ld_wb_reg", 32'(WriteRegW), 32'h3);

        // store, ack in first BUSY cycle
        MemWriteM = 1; alu_outM = 16'h0022; WriteDataM = 16'h1234; WriteRegM = 4'h7; #1;
        chk("st_idle_stall", 32'(stall), 32'h1);
        cyc();
        dmem.ack = 1; #1;
        chk("st_req", 32'(dmem.req), 32'h1);
        chk("st_we", 32'(dmem.we), 32'h1);
        chk("st_addr", 32'(dmem.addr), 32'h22);
        chk("st_wdata", 32'(dmem.wdata), 32'h1234);
        chk("st_busy_stall", 32'(stall), 32'h1);
        cyc();
        chk("st_done_req", 32'(dmem.req), 32'h0);
        chk("st_done_stall", 32'(stall), 32'h0);
        cyc();
        nop(); #1;
        chk("st_wb_regw", 32'(RegWriteW), 32'h0);
        chk("st_wb_alu", 32'(alu_outW), 32'h0022);
        chk("st_wb_reg", 32'(WriteRegW), 32'h7);
        chk("idle_ack_ignored", 32'(stall), 32'h0);
        cyc();
        dmem.ack = 0; #1;
        chk("idle_ack_noreq", 32'(dmem.req), 32'h0);

        // back-to-back loads with immediate ack
        req_rises = 0;
        MemReadM = 1; alu_outM = 16'h0001; RegWriteM = 1; MemToRegM = 1; WriteRegM = 4'h1; #1;
        chk("bb1_idle_stall", 32'(stall), 32'h1);
        cyc();
        dmem.ack = 1; dmem.rdata = 16'h1111; #1;
        chk("bb1_addr", 32'(dmem.addr), 32'h01);
        cyc();
        dmem.ack = 0; #1;
        chk("bb1_done_req", 32'(dmem.req), 32'h0);
        chk("bb1_done_bubble", 32'(RegWriteW), 32'h0);
        cyc();
        alu_outM = 16'h0002; WriteRegM = 4'h2; #1;
        chk("bb1_wb_data", 32'(ReadDataW), 32'h1111);
        chk("bb1_wb_reg", 32'(WriteRegW), 32'h1);
        chk("bb1_wb_regw", 32'(RegWriteW), 32'h1);
        chk("bb2_idle_stall", 32'(stall), 32'h1);
        chk("bb2_idle_req", 32'(dmem.req), 32'h0);
        cyc();
        dmem.ack = 1; dmem.rdata = 16'h2222; #1;
        chk("bb2_addr", 32'(dmem.addr), 32'h02);
        chk("bb2_bubble", 32'(RegWriteW), 32'h0);
        cyc();
        dmem.ack = 0; #1;
        chk("bb2_done_bubble", 32'(RegWriteW), 32'h0);
        cyc();
        nop(); #1;
        chk("bb2_wb_data", 32'(ReadDataW), 32'h2222);
        chk("bb2_wb_reg", 32'(WriteRegW), 32'h2);
        chk("bb2_wb_regw", 32'(RegWriteW), 32'h1);
        chk("bb_req_count", 32'(req_rises), 32'd2);

        // asynchronous reset in the middle of a pending load
        MemReadM = 1; alu_outM = 16'h0010; RegWriteM = 1; MemToRegM = 1; WriteRegM = 4'h3; #1;
        cyc();
        chk("mid_busy_req", 32'(dmem.req), 32'h1);
        #2;
        rst_n = 1'b0;
        nop(); #1;
        chk("mid_rst_req", 32'(dmem.req), 32'h0);
        chk("mid_rst_addr", 32'(dmem.addr), 32'h0);
        chk("mid_rst_rdataw", 32'(ReadDataW), 32'h0);
        chk("mid_rst_regw", 32'(WriteRegW), 32'h0);
        chk("mid_rst_stall", 32'(stall), 32'h0);
        dmem.ack = 1; dmem.rdata = 16'h5555;
        cyc();
        #2;
        rst_n = 1'b1;
        cyc();
        chk("late_ack_req", 32'(dmem.req), 32'h0);
        chk("late_ack_stall", 32'(stall), 32'h0);
        chk("late_ack_rdataw", 32'(ReadDataW), 32'h0);
        dmem.ack = 0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
